// File: rtl/controle_partida_if.sv
// Signal bundle between the match sequencer, the player inputs, the judge and the display.
// The slave modport is the sequencer's view. The master modport is the surrounding logic's view.
interface controle_partida_if #(
    parameter int SW = 3
);
    logic          Prs;
    logic [4:0]    selA;
    logic          okA;
    logic [4:0]    selB;
    logic          okB;
    logic [4:0]    jA;
    logic [4:0]    jB;
    logic          jPA;
    logic          jPB;
    logic          jE;
    logic          lockA;
    logic          lockB;
    logic [1:0]    res;
    logic          res_v;
    logic [SW-1:0] scA;
    logic [SW-1:0] scB;
    logic          fim;
    logic          venc;
    logic [2:0]    estado;

    modport slave (
        input  Prs, selA, okA, selB, okB, jPA, jPB, jE,
        output jA, jB, lockA, lockB, res, res_v, scA, scB, fim, venc, estado
    );

    modport master (
        output Prs, selA, okA, selB, okB, jPA, jPB, jE,
        input  jA, jB, lockA, lockB, res, res_v, scA, scB, fim, venc, estado
    );
endinterface

// File: rtl/controle_partida.sv
// Match sequencer for the two-player five-choice game.
// Each player's choice stays hidden until both players have locked.
// The sequencer then shows both choices to the judge and samples the verdict.
// It keeps a score per player until one player reaches WIN.
module controle_partida #(
    parameter int WIN      = 3,
    parameter int SHOW_CYC = 4,
    parameter int SW       = 3
) (
    input  logic              clk,
    input  logic              rst,
    controle_partida_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COLETA = 3'd1,
        AVAL   = 3'd2,
        MOSTRA = 3'd3,
        FIM    = 3'd4
    } state_t;

    localparam int             CW       = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SHOW_CYC - 1);
    localparam logic [SW-1:0]  WIN_SC   = SW'(WIN);

    state_t        state_q, state_d;
    logic [4:0]    reg_a_q, reg_a_d;
    logic [4:0]    reg_b_q, reg_b_d;
    logic          lock_a_q, lock_a_d;
    logic          lock_b_q, lock_b_d;
    logic [1:0]    res_q, res_d;
    logic          res_v_q, res_v_d;
    logic [SW-1:0] sc_a_q, sc_a_d;
    logic [SW-1:0] sc_b_q, sc_b_d;
    logic          venc_q, venc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and datapath registers; reset returns everything to the idle state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            lock_a_q <= 1'b0;
            lock_b_q <= 1'b0;
            res_q    <= 2'b00;
            res_v_q  <= 1'b0;
            sc_a_q   <= '0;
            sc_b_q   <= '0;
            venc_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            lock_a_q <= lock_a_d;
            lock_b_q <= lock_b_d;
            res_q    <= res_d;
            res_v_q  <= res_v_d;
            sc_a_q   <= sc_a_d;
            sc_b_q   <= sc_b_d;
            venc_q   <= venc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: lock collection, verdict sampling, show timer, and match end.
    always_comb begin
        // NOTE: hold every register by default so that no branch can infer a latch.
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        lock_a_d = lock_a_q;
        lock_b_d = lock_b_q;
        res_d    = res_q;
        res_v_d  = 1'b0;
        sc_a_d   = sc_a_q;
        sc_b_d   = sc_b_q;
        venc_d   = venc_q;
        cnt_d    = cnt_q;

        if (bus.Prs) begin
            // A start or restart wins over any lock strobe or verdict in the same cycle.
            state_d  = COLETA;
            lock_a_d = 1'b0;
            lock_b_d = 1'b0;
            res_d    = 2'b00;
            sc_a_d   = '0;
            sc_b_d   = '0;
            venc_d   = 1'b0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                COLETA: begin
                    if (bus.okA && $onehot(bus.selA) && !lock_a_q) begin
                        reg_a_d  = bus.selA;
                        lock_a_d = 1'b1;
                    end
                    if (bus.okB && $onehot(bus.selB) && !lock_b_q) begin
                        reg_b_d  = bus.selB;
                        lock_b_d = 1'b1;
                    end
                    if (lock_a_d && lock_b_d) begin
                        state_d = AVAL;
                    end
                end
                AVAL: begin
                    // The draw verdict has priority. A cycle with no verdict asserted also counts as a draw.
                    if (bus.jE) begin
                        res_d = 2'b11;
                    end else if (bus.jPA) begin
                        res_d  = 2'b01;
                        sc_a_d = sc_a_q + SW'(1);
                    end else if (bus.jPB) begin
                        res_d  = 2'b10;
                        sc_b_d = sc_b_q + SW'(1);
                    end else begin
                        res_d = 2'b11;
                    end
                    res_v_d = 1'b1;
                    cnt_d   = '0;
                    state_d = MOSTRA;
                end
                MOSTRA: begin
                    if (cnt_q == CNT_LAST) begin
                        if (sc_a_q == WIN_SC) begin
                            state_d = FIM;
                            venc_d  = 1'b0;
                        end else if (sc_b_q == WIN_SC) begin
                            state_d = FIM;
                            venc_d  = 1'b1;
                        end else begin
                            state_d  = COLETA;
                            lock_a_d = 1'b0;
                            lock_b_d = 1'b0;
                            res_d    = 2'b00;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                FIM: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // The judge sees the choices only after both are latched. They stay visible through the show and end phases.
    always_comb begin
        if (state_q == AVAL || state_q == MOSTRA || state_q == FIM) begin
            bus.jA = reg_a_q;
            bus.jB = reg_b_q;
        end else begin
            bus.jA = '0;
            bus.jB = '0;
        end
    end

    assign bus.lockA  = lock_a_q;
    assign bus.lockB  = lock_b_q;
    assign bus.res    = res_q;
    assign bus.res_v  = res_v_q;
    assign bus.scA    = sc_a_q;
    assign bus.scB    = sc_b_q;
    assign bus.fim    = (state_q == FIM);
    assign bus.venc   = venc_q;
    assign bus.estado = state_q;

endmodule
